// File: rtl/coef_calc_pkg.sv
// Shared constants, state encoding and Q10.10 saturation helper for the
// least-squares coefficient calculator.
package coef_calc_pkg;

    localparam int N_SAMPLES = 150;
    localparam int W         = 20;
    localparam int FRAC_BITS = 10;
    localparam int CNT_W     = 8;
    localparam int SUM_W     = 28;
    localparam int PSUM_W    = 48;
    localparam int DVD_W     = 68;
    localparam int DVS_W     = 58;

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        NUM,
        DIV_B1,
        B0_PREP,
        DIV_B0,
        FIN
    } state_t;

    // Clamp a wide divider quotient into the signed Q10.10 coefficient range.
    function automatic logic signed [W-1:0] sat_coef(input logic signed [DVD_W-1:0] q);
        if (q > DVD_W'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (q < DVD_W'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return q[W-1:0];
        end
    endfunction

endpackage

// File: rtl/coef_calc_seq_div.sv
// Signed restoring divider: one quotient bit per cycle, quotient truncated
// toward zero. A start while busy abandons the running division.
module seq_div
    import coef_calc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [DVD_W-1:0] dividend,
    input  logic signed [DVS_W-1:0] divisor,
    output logic                    busy,
    output logic                    done,
    output logic signed [DVD_W-1:0] quotient
);

    logic [DVD_W-1:0] dvd_q;
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W-1:0] rem_q;
    logic             neg_q;
    logic [6:0]       cnt_q;
    logic [DVS_W:0]   rem_shift;
    logic             fits;

    // Magnitudes are divided unsigned; dividend bits shift out of dvd_q while
    // quotient bits shift in, so dvd_q holds the quotient magnitude at the end.
    always_comb begin
        rem_shift = {rem_q, dvd_q[DVD_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvd_q <= dividend[DVD_W-1] ? DVD_W'(-dividend) : DVD_W'(dividend);
                dvs_q <= divisor[DVS_W-1] ? DVS_W'(-divisor) : DVS_W'(divisor);
                rem_q <= '0;
                neg_q <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
                cnt_q <= 7'(DVD_W);
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= fits ? DVS_W'(rem_shift - {1'b0, dvs_q}) : rem_shift[DVS_W-1:0];
                dvd_q <= {dvd_q[DVD_W-2:0], fits};
                cnt_q <= cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = neg_q ? DVD_W'(-dvd_q) : dvd_q;

endmodule

// File: rtl/coef_calc.sv
// Least-squares line fit over N_SAMPLES Q10.10 (x,y) pairs: accumulates the
// sums, then derives slope b1 and intercept b0 with one shared divider.
module coef_calc #(
    parameter int N_SAMPLES = coef_calc_pkg::N_SAMPLES,
    parameter int W         = coef_calc_pkg::W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                en_coef,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output logic                coef_done,
    output logic                coef_finish,
    output logic signed [W-1:0] b1,
    output logic signed [W-1:0] b0,
    output logic                degenerate
);
    import coef_calc_pkg::*;

    localparam int PROD_W = 2 * SUM_W;
    localparam logic signed [DVS_W-1:0] B0_DIVISOR = DVS_W'(N_SAMPLES) <<< FRAC_BITS;

    state_t state_q, state_d;

    logic        [CNT_W-1:0]    cnt_q;
    logic signed [SUM_W-1:0]    sx_q, sy_q;
    logic signed [PSUM_W-1:0]   sxy_q, sxx_q;
    logic signed [W-1:0]        b1_q;
    logic                       deg_q;

    logic signed [2*W-1:0]      xy_c, xx_c;
    logic signed [PROD_W-1:0]   n_sxy, n_sxx, sx_sy, sx_sx;
    logic signed [W+SUM_W-1:0]  b1_sx;
    logic signed [DVD_W-1:0]    num_c, den_wide, t_c;
    logic signed [DVS_W-1:0]    den_c;
    logic                       den_zero;

    logic                       div_start, div_busy, div_done;
    logic signed [DVD_W-1:0]    div_dividend, div_quotient;
    logic signed [DVS_W-1:0]    div_divisor;

    // num is pre-shifted by FRAC_BITS so num/den lands directly in Q10.10;
    // t is at Q*.20 so dividing by N<<10 yields b0 in Q10.10 with one truncation.
    always_comb begin
        xy_c     = (2*W)'(x_in) * (2*W)'(y_in);
        xx_c     = (2*W)'(x_in) * (2*W)'(x_in);
        n_sxy    = PROD_W'(sxy_q) * PROD_W'(N_SAMPLES);
        n_sxx    = PROD_W'(sxx_q) * PROD_W'(N_SAMPLES);
        sx_sy    = PROD_W'(sx_q) * PROD_W'(sy_q);
        sx_sx    = PROD_W'(sx_q) * PROD_W'(sx_q);
        num_c    = (DVD_W'(n_sxy) - DVD_W'(sx_sy)) <<< FRAC_BITS;
        den_wide = DVD_W'(n_sxx) - DVD_W'(sx_sx);
        den_c    = DVS_W'(den_wide);
        den_zero = (den_wide == '0);
        b1_sx    = (W+SUM_W)'(b1_q) * (W+SUM_W)'(sx_q);
        t_c      = (DVD_W'(sy_q) <<< FRAC_BITS) - DVD_W'(b1_sx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The divider is launched on the edge that leaves NUM or B0_PREP, so each
    // DIV state simply waits for its done pulse.
    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        div_dividend = num_c;
        div_divisor  = den_c;
        if (start) begin
            state_d = ACC;
        end else begin
            case (state_q)
                IDLE: ;
                ACC: begin
                    if (en_coef && (cnt_q == CNT_W'(N_SAMPLES - 1))) begin
                        state_d = NUM;
                    end
                end
                NUM: begin
                    if (den_zero) begin
                        state_d = B0_PREP;
                    end else if (!div_busy) begin
                        div_start = 1'b1;
                        state_d   = DIV_B1;
                    end
                end
                DIV_B1: begin
                    if (div_done) begin
                        state_d = B0_PREP;
                    end
                end
                B0_PREP: begin
                    div_start    = 1'b1;
                    div_dividend = t_c;
                    div_divisor  = B0_DIVISOR;
                    state_d      = DIV_B0;
                end
                DIV_B0: begin
                    if (div_done) begin
                        state_d = FIN;
                    end
                end
                FIN: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Visible coefficients change only on entry to FIN; b1_q/deg_q are the
    // working copies used while b0 is still being computed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            sxy_q       <= '0;
            sxx_q       <= '0;
            b1_q        <= '0;
            deg_q       <= 1'b0;
            coef_done   <= 1'b0;
            coef_finish <= 1'b0;
            b1          <= '0;
            b0          <= '0;
            degenerate  <= 1'b0;
        end else begin
            coef_done <= 1'b0;
            if (start) begin
                cnt_q       <= '0;
                sx_q        <= '0;
                sy_q        <= '0;
                sxy_q       <= '0;
                sxx_q       <= '0;
                coef_finish <= 1'b0;
            end else begin
                case (state_q)
                    ACC: begin
                        if (en_coef) begin
                            sx_q      <= sx_q + SUM_W'(x_in);
                            sy_q      <= sy_q + SUM_W'(y_in);
                            sxy_q     <= sxy_q + PSUM_W'(xy_c);
                            sxx_q     <= sxx_q + PSUM_W'(xx_c);
                            cnt_q     <= cnt_q + CNT_W'(1);
                            coef_done <= 1'b1;
                        end
                    end
                    NUM: begin
                        deg_q <= den_zero;
                        if (den_zero) begin
                            b1_q <= '0;
                        end
                    end
                    DIV_B1: begin
                        if (div_done) begin
                            b1_q <= sat_coef(div_quotient);
                        end
                    end
                    DIV_B0: begin
                        if (div_done) begin
                            b1          <= b1_q;
                            b0          <= sat_coef(div_quotient);
                            degenerate  <= deg_q;
                            coef_finish <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    seq_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

endmodule

// File: tb/tb_coef_calc.sv
// Scoreboard bench for coef_calc: directed regressions push expected results,
// a monitor pops and compares them whenever coef_finish rises.
module tb_coef_calc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               en_coef;
    logic signed [19:0] x_in;
    logic signed [19:0] y_in;
    logic               coef_done;
    logic               coef_finish;
    logic signed [19:0] b1;
    logic signed [19:0] b0;
    logic               degenerate;

    always #5 clk = ~clk;

    coef_calc #(.N_SAMPLES(150), .W(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .en_coef     (en_coef),
        .x_in        (x_in),
        .y_in        (y_in),
        .coef_done   (coef_done),
        .coef_finish (coef_finish),
        .b1          (b1),
        .b0          (b0),
        .degenerate  (degenerate)
    );

    typedef struct {
        logic [19:0] b1;
        logic [19:0] b0;
        logic        deg;
        int          dones;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_cnt   = 0;
    int   since_done = 0;
    logic fin_prev   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [19:0] e_b1, input logic [19:0] e_b0,
                                input logic e_deg);
        exp_t e;
        e.b1    = e_b1;
        e.b0    = e_b0;
        e.deg   = e_deg;
        e.dones = 150;
        exp_q.push_back(e);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: x=k, y=2x+1; mode 1: x=k, y=-x+3; mode 2: x=1.0, y=k LSBs
    task automatic applyStimulus(input int mode, input int n_en);
        for (int k = 0; k < n_en; k++) begin
            @(negedge clk);
            en_coef = 1'b1;
            case (mode)
                0: begin
                    x_in = 20'(k * 1024);
                    y_in = (k < 150) ? 20'((2 * k + 1) * 1024) : 20'd0;
                end
                1: begin
                    x_in = 20'(k * 1024);
                    y_in = 20'((3 - k) * 1024);
                end
                default: begin
                    x_in = 20'h00400;
                    y_in = 20'(k);
                end
            endcase
        end
        @(negedge clk);
        en_coef = 1'b0;
    endtask

    task automatic waitFinish(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (coef_finish) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || start) begin
                done_cnt = 0;
            end else if (coef_done) begin
                done_cnt++;
            end
            if (coef_done) begin
                since_done = 0;
            end else begin
                since_done++;
            end
            if (coef_finish && !fin_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_finish: got b1=0x%0h b0=0x%0h, expected no result",
                             b1, b0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("b1", {12'd0, b1}, {12'd0, e.b1});
                    checkOutput("b0", {12'd0, b0}, {12'd0, e.b0});
                    checkOutput("degenerate", {31'd0, degenerate}, {31'd0, e.deg});
                    checkOutput("done_count", done_cnt, e.dones);
                    checkOutput("latency_le_145", {31'd0, (since_done <= 145)}, 32'd1);
                end
            end
            fin_prev = coef_finish;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : stimulus
        rst_n   = 1'b0;
        start   = 1'b0;
        en_coef = 1'b0;
        x_in    = '0;
        y_in    = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_coef_done", {31'd0, coef_done}, 32'd0);
        checkOutput("rst_coef_finish", {31'd0, coef_finish}, 32'd0);
        checkOutput("rst_b1", {12'd0, b1}, 32'd0);
        checkOutput("rst_b0", {12'd0, b0}, 32'd0);
        checkOutput("rst_degenerate", {31'd0, degenerate}, 32'd0);

        applyStimulus(0, 5);
        @(negedge clk);
        checkOutput("idle_ignores_en", done_cnt, 0);

        $display("[TB] run A: y = 2x + 1");
        pushExpected(20'h00800, 20'h00400, 1'b0);
        pulseStart();
        applyStimulus(0, 150);
        waitFinish("finish_a");

        $display("[TB] run B: y = -x + 3");
        pulseStart();
        checkOutput("finish_cleared_by_start", {31'd0, coef_finish}, 32'd0);
        checkOutput("b1_held_after_start", {12'd0, b1}, 32'h00800);
        pushExpected(20'hFFC00, 20'h00C00, 1'b0);
        applyStimulus(1, 150);
        waitFinish("finish_b");

        $display("[TB] run C: constant x");
        pushExpected(20'h00000, 20'h0004A, 1'b1);
        pulseStart();
        applyStimulus(2, 150);
        waitFinish("finish_c");

        $display("[TB] run D: en_coef held for 160 cycles");
        pushExpected(20'h00800, 20'h00400, 1'b0);
        pulseStart();
        applyStimulus(0, 160);
        waitFinish("finish_d");

        $display("[TB] run E: reset after 70 samples");
        pulseStart();
        applyStimulus(0, 70);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_b1", {12'd0, b1}, 32'd0);
        checkOutput("midrst_b0", {12'd0, b0}, 32'd0);
        checkOutput("midrst_degenerate", {31'd0, degenerate}, 32'd0);
        checkOutput("midrst_coef_finish", {31'd0, coef_finish}, 32'd0);
        pushExpected(20'hFFC00, 20'h00C00, 1'b0);
        pulseStart();
        applyStimulus(1, 150);
        waitFinish("finish_after_reset");

        $display("[TB] run F: start during slope division");
        pulseStart();
        applyStimulus(0, 150);
        repeat (20) @(negedge clk);
        pulseStart();
        checkOutput("abort_finish_low", {31'd0, coef_finish}, 32'd0);
        pushExpected(20'hFFC00, 20'h00C00, 1'b0);
        applyStimulus(1, 150);
        waitFinish("finish_after_abort");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
